// File: rtl/fb_dump_pkg.sv
// Shared types and helpers for the frame-buffer UART dump engine.
package fb_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_SEND,
    ST_CKSUM,
    ST_FIN
  } dump_state_t;

  localparam logic [7:0] HDR_SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] HDR_W_DEFAULT    = 8'hFF;
  localparam logic [7:0] HDR_H_DEFAULT    = 8'hEF;

  // Header dimension bytes carry the last valid index, not the count.
  function automatic logic [7:0] hdr_dim(input int n);
    return 8'(n - 1);
  endfunction

  function automatic logic [7:0] pix_byte(input logic [5:0] pix);
    return {2'b00, pix};
  endfunction

endpackage

// File: rtl/fb_uart_dump_if.sv
// UART byte handshake plus frame-buffer read port of the dump engine.
interface fb_uart_dump_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] fb_rd_x;
  logic [7:0] fb_rd_y;
  logic       fb_rd_en;
  logic [5:0] fb_rd_data;
  logic       busy;
  logic       done;

  modport slave (
    input  rx_data, rx_valid, tx_ready, fb_rd_data,
    output rx_ack, tx_data, tx_valid, fb_rd_x, fb_rd_y, fb_rd_en, busy, done
  );

  modport master (
    output rx_data, rx_valid, tx_ready, fb_rd_data,
    input  rx_ack, tx_data, tx_valid, fb_rd_x, fb_rd_y, fb_rd_en, busy, done
  );
endinterface

// File: rtl/fb_scan_counter.sv
// Raster x/y scan counter; x runs fastest and wraps into y.
module fb_scan_counter #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       adv,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic [7:0] x_nxt,
  output logic [7:0] y_nxt,
  output logic       last
);

  logic [7:0] x_q, x_d, y_q, y_d;
  logic       last_x;

  always_comb begin
    last_x = (x_q == 8'(WIDTH - 1));
    last   = last_x && (y_q == 8'(HEIGHT - 1));
    x_nxt  = last_x ? 8'd0 : x_q + 8'd1;
    y_nxt  = last_x ? y_q + 8'd1 : y_q;
    x_d    = x_q;
    y_d    = y_q;
    if (clr) begin
      x_d = 8'd0;
      y_d = 8'd0;
    end else if (adv) begin
      x_d = x_nxt;
      y_d = y_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q <= 8'd0;
      y_q <= 8'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/fb_uart_dump.sv
// Frame-buffer readback: on 'D' streams sync/size header, every pixel and an
// 8-bit pixel checksum over UART; 'X' aborts after the byte in flight.
module fb_uart_dump
  import fb_dump_pkg::*;
#(
  parameter int         WIDTH     = 256,
  parameter int         HEIGHT    = 240,
  parameter logic [7:0] CMD_DUMP  = 8'h44,
  parameter logic [7:0] CMD_ABORT = 8'h58,
  parameter logic [7:0] SYNC_BYTE = HDR_SYNC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  fb_uart_dump_if.slave   bus
);

  dump_state_t state_q, state_d;
  logic [1:0]  hdr_idx_q, hdr_idx_d;
  logic [7:0]  tx_data_q, tx_data_d, cksum_q, cksum_d;
  logic [7:0]  rd_x_q, rd_x_d, rd_y_q, rd_y_d;
  logic        tx_valid_q, tx_valid_d, rd_en_q, rd_en_d;
  logic        rx_ack_q, rx_ack_d, busy_q, busy_d, done_q, done_d;
  logic        abort_pend_q, abort_pend_d;
  logic        cnt_clr, cnt_adv, cnt_last;
  logic [7:0]  cnt_x, cnt_y, cnt_x_nxt, cnt_y_nxt;
  logic        xfer, rx_new, is_abort;

  fb_scan_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_scan (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .adv   (cnt_adv),
    .x     (cnt_x),
    .y     (cnt_y),
    .x_nxt (cnt_x_nxt),
    .y_nxt (cnt_y_nxt),
    .last  (cnt_last)
  );

  always_comb begin
    xfer         = tx_valid_q && bus.tx_ready;
    // A byte seen while the ack is high was already consumed.
    rx_new       = bus.rx_valid && !rx_ack_q;
    is_abort     = rx_new && (bus.rx_data == CMD_ABORT);
    state_d      = state_q;
    hdr_idx_d    = hdr_idx_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    cksum_d      = cksum_q;
    rd_x_d       = rd_x_q;
    rd_y_d       = rd_y_q;
    rd_en_d      = 1'b0;
    rx_ack_d     = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    abort_pend_d = abort_pend_q;
    cnt_clr      = 1'b0;
    cnt_adv      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_new) begin
          rx_ack_d = 1'b1;
          if (bus.rx_data == CMD_DUMP) begin
            state_d      = ST_HDR;
            hdr_idx_d    = 2'd0;
            tx_data_d    = SYNC_BYTE;
            tx_valid_d   = 1'b1;
            cksum_d      = 8'd0;
            busy_d       = 1'b1;
            abort_pend_d = 1'b0;
            cnt_clr      = 1'b1;
          end
        end
      end
      ST_HDR: begin
        if (xfer) begin
          case (hdr_idx_q)
            2'd0: begin
              tx_data_d = hdr_dim(WIDTH);
              hdr_idx_d = 2'd1;
            end
            2'd1: begin
              tx_data_d = hdr_dim(HEIGHT);
              hdr_idx_d = 2'd2;
            end
            default: begin
              tx_valid_d = 1'b0;
              rd_en_d    = 1'b1;
              rd_x_d     = cnt_x;
              rd_y_d     = cnt_y;
              state_d    = ST_RD_REQ;
            end
          endcase
        end
      end
      ST_RD_REQ: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        tx_data_d  = pix_byte(bus.fb_rd_data);
        cksum_d    = cksum_q + pix_byte(bus.fb_rd_data);
        tx_valid_d = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (xfer) begin
          if (cnt_last) begin
            tx_data_d = cksum_q;
            state_d   = ST_CKSUM;
          end else begin
            tx_valid_d = 1'b0;
            cnt_adv    = 1'b1;
            rd_en_d    = 1'b1;
            rd_x_d     = cnt_x_nxt;
            rd_y_d     = cnt_y_nxt;
            state_d    = ST_RD_REQ;
          end
        end
      end
      ST_CKSUM: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = ST_FIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort waits for any offered byte to transfer, then drops to idle.
    if (busy_q) begin
      if (rx_new) rx_ack_d = 1'b1;
      if (is_abort) abort_pend_d = 1'b1;
      if ((abort_pend_q || is_abort) && (!tx_valid_q || xfer)) begin
        state_d      = ST_IDLE;
        tx_valid_d   = 1'b0;
        rd_en_d      = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        abort_pend_d = 1'b0;
        cnt_adv      = 1'b0;
        cnt_clr      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      hdr_idx_q    <= 2'd0;
      tx_data_q    <= 8'd0;
      tx_valid_q   <= 1'b0;
      cksum_q      <= 8'd0;
      rd_x_q       <= 8'd0;
      rd_y_q       <= 8'd0;
      rd_en_q      <= 1'b0;
      rx_ack_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_idx_q    <= hdr_idx_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      cksum_q      <= cksum_d;
      rd_x_q       <= rd_x_d;
      rd_y_q       <= rd_y_d;
      rd_en_q      <= rd_en_d;
      rx_ack_q     <= rx_ack_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign bus.rx_ack   = rx_ack_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.fb_rd_x  = rd_x_q;
  assign bus.fb_rd_y  = rd_y_q;
  assign bus.fb_rd_en = rd_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_fb_uart_dump.sv
// Scoreboard bench for fb_uart_dump on a reduced 32x6 frame.
module tb_fb_uart_dump;

  localparam int W = 32;
  localparam int H = 6;
  localparam int P = W * H;
  localparam logic [7:0] C_D = 8'h44;
  localparam logic [7:0] C_X = 8'h58;
  localparam logic [7:0] C_Q = 8'h51;

  logic clk = 1'b0;
  logic rst = 1'b0;
  fb_uart_dump_if bus();

  fb_uart_dump #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int ack_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int ack_cyc = 0;
  bit rand_rdy = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Frame buffer: (x+y)&3F one cycle after the strobe, junk otherwise.
  initial begin
    logic en;
    logic [7:0] ax, ay;
    bus.fb_rd_data = 6'h3F;
    forever begin
      @(posedge clk);
      en = bus.fb_rd_en;
      ax = bus.fb_rd_x;
      ay = bus.fb_rd_y;
      #1;
      bus.fb_rd_data = (en === 1'b1) ? 6'((ax + ay) & 8'h3F) : (6'h2A ^ ax[5:0]);
    end
  end

  // Monitor: scoreboard pop on transfers, stall stability, pulse checks.
  initial begin
    logic       held_v;
    logic [7:0] held_d;
    logic       ack_prev, done_prev;
    logic [7:0] e;
    held_v = 1'b0; held_d = 8'd0; ack_prev = 1'b0; done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_valid === 1'b1) begin
        if (held_v) chk("tx_stable", bus.tx_data, held_d);
        held_v = (bus.tx_ready !== 1'b1);
        held_d = bus.tx_data;
        if (bus.tx_ready === 1'b1) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none", bus.tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte", bus.tx_data, e);
          end
        end
      end else begin
        held_v = 1'b0;
      end
      if (bus.rx_ack === 1'b1) begin
        ack_cnt++;
        chk("ack_not_consecutive", ack_prev, 1'b0);
      end
      ack_prev = (bus.rx_ack === 1'b1);
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_single", done_prev, 1'b0);
      end
      done_prev = (bus.done === 1'b1);
    end
  end

  task automatic push_dump();
    logic [7:0] sum, p;
    sum = 8'd0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(W - 1));
    exp_q.push_back(8'(H - 1));
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        p = 8'((x + y) & 8'h3F);
        exp_q.push_back(p);
        sum = sum + p;
      end
    exp_q.push_back(sum);
  endtask

  task automatic send_cmd(input logic [7:0] b, output logic o_busy, output logic o_txv,
                          output logic [7:0] o_txd);
    int n, a0;
    a0 = ack_cnt;
    @(posedge clk);
    #1;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.rx_ack !== 1'b1 && n < 8);
    ack_cyc = cyc;
    o_busy = bus.busy;
    o_txv  = bus.tx_valid;
    o_txd  = bus.tx_data;
    chk("rx_ack_seen", bus.rx_ack, 1'b1);
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rx_ack_once", ack_cnt - a0, 1);
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("busy_fall_timeout", bus.busy, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_vals();
    chk("rst_rx_ack", bus.rx_ack, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_fb_rd_en", bus.fb_rd_en, 0);
    chk("rst_fb_rd_x", bus.fb_rd_x, 0);
    chk("rst_fb_rd_y", bus.fb_rd_y, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
  endtask

  task automatic run_full(input bit chk_time);
    int d0, b0;
    logic sb, sv;
    logic [7:0] sd;
    push_dump();
    d0 = done_cnt;
    b0 = xfer_cnt;
    send_cmd(C_D, sb, sv, sd);
    chk("start_busy", sb, 1'b1);
    chk("start_tx_valid", sv, 1'b1);
    chk("start_tx_data", sd, 8'hA5);
    wait_idle(4000);
    chk("done_count", done_cnt - d0, 1);
    chk("queue_drained", exp_q.size(), 0);
    chk("byte_total", xfer_cnt - b0, 3 + P + 1);
    if (chk_time) chk("dump_cycles", done_cyc - ack_cyc, 4 + 3 * P);
  endtask

  initial begin
    logic sb, sv;
    logic [7:0] sd;
    int b0, d0, got, n;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Full dump with ready held high.
    run_full(1'b1);

    // Stray byte in idle, then a dump under random backpressure with a 'D' mid-stream.
    send_cmd(C_Q, sb, sv, sd);
    chk("q_not_busy", sb, 1'b0);
    chk("q_no_tx", sv, 1'b0);
    rand_rdy = 1'b1;
    push_dump();
    d0 = done_cnt;
    b0 = xfer_cnt;
    send_cmd(C_D, sb, sv, sd);
    chk("rnd_start_data", sd, 8'hA5);
    repeat (60) @(posedge clk);
    send_cmd(C_D, sb, sv, sd);
    chk("d_while_busy_busy", sb, 1'b1);
    wait_idle(8000);
    chk("rnd_done_count", done_cnt - d0, 1);
    chk("rnd_queue_drained", exp_q.size(), 0);
    chk("rnd_byte_total", xfer_cnt - b0, 3 + P + 1);
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);

    // Abort after 100 pixel bytes.
    push_dump();
    d0 = done_cnt;
    b0 = xfer_cnt;
    send_cmd(C_D, sb, sv, sd);
    n = 0;
    while (xfer_cnt - b0 < 103 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_timeout", (xfer_cnt - b0 >= 103), 1'b1);
    send_cmd(C_X, sb, sv, sd);
    chk("abort_idle_busy", sb, 1'b0);
    chk("abort_idle_txv", sv, 1'b0);
    repeat (20) @(negedge clk);
    got = xfer_cnt - b0;
    chk("abort_inflight_done", (got == 103 || got == 104), 1'b1);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_busy_low", bus.busy, 1'b0);
    exp_q.delete();
    run_full(1'b1);

    // Reset in the middle of pixel (17,3).
    push_dump();
    send_cmd(C_D, sb, sv, sd);
    n = 0;
    while (!(bus.fb_rd_en === 1'b1 && bus.fb_rd_x == 8'd17 && bus.fb_rd_y == 8'd3) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_17_3", bus.fb_rd_en, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_full(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
